// File: rtl/lcd_bus_arbiter.sv
// Owns the 4-bit HD44780 bus: runs power-on init, then round-robins byte requests
// from two requesters, emitting each byte as two timed nibble strobes.
module lcd_bus_arbiter #(
  parameter int INIT_WAIT = 60000,
  parameter int EN_CYCLES = 800,
  parameter int CMD_WAIT  = 60000,
  parameter int CW        = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_byte,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_byte,
  output logic       req1_ready,
  output logic       rs,
  output logic       en,
  output logic [3:0] data,
  output logic       busy,
  output logic       init_done
);
  typedef enum logic [2:0] {
    S_RESET_WAIT, S_INIT, S_IDLE, S_HI_ON, S_HI_OFF, S_LO_ON, S_LO_OFF, S_CMD_WAIT
  } state_t;

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT - 1);
  localparam logic [CW-1:0] EN_LAST   = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_WAIT - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    step_q;
  logic          last_grant_q, init_done_q, nib_only_q, rs_lat_q;
  logic [7:0]    byte_q;
  logic          rs_q, en_q;
  logic [3:0]    data_q;

  // {nibble_only, byte}; nibble-only steps carry their nibble in [7:4]
  function automatic logic [8:0] init_step(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: init_step = {1'b1, 8'h30};
      3'd3:             init_step = {1'b1, 8'h20};
      3'd4:             init_step = {1'b0, 8'h28};
      3'd5:             init_step = {1'b0, 8'h0C};
      3'd6:             init_step = {1'b0, 8'h06};
      default:          init_step = {1'b0, 8'h01};
    endcase
  endfunction

  logic [8:0] step_ent;
  logic       g0, g1, sel_rs, slow, en_done, xfer_end, init_load;
  logic [7:0] sel_byte;

  assign step_ent = init_step(step_q[2:0]);
  assign en_done  = (cnt_q == EN_LAST);
  assign slow     = ~rs_lat_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
  assign xfer_end = (state_q == S_HI_OFF && nib_only_q && en_done) ||
                    (state_q == S_LO_OFF && en_done && !slow) ||
                    (state_q == S_CMD_WAIT && cnt_q == CMD_LAST);
  // Init steps chain back-to-back so every en-low window is exactly EN_CYCLES
  assign init_load = (state_q == S_INIT) ||
                     (xfer_end && !init_done_q && step_q != 4'd8);

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state_q == S_IDLE && init_done_q) begin
      if (req0_valid && req1_valid) begin
        g0 = last_grant_q;
        g1 = ~last_grant_q;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
  end

  assign sel_rs   = g1 ? req1_rs   : req0_rs;
  assign sel_byte = g1 ? req1_byte : req0_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET_WAIT;
      cnt_q        <= '0;
      step_q       <= '0;
      last_grant_q <= 1'b1;
      init_done_q  <= 1'b0;
      nib_only_q   <= 1'b0;
      rs_lat_q     <= 1'b0;
      byte_q       <= '0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      data_q       <= '0;
    end else begin
      if (state_q != S_IDLE) cnt_q <= cnt_q + 1'b1;
      if (init_load) begin
        {nib_only_q, byte_q} <= step_ent;
        rs_lat_q <= 1'b0;
        step_q   <= step_q + 4'd1;
        state_q  <= S_HI_ON;
        cnt_q    <= '0;
        en_q     <= 1'b1;
        rs_q     <= 1'b0;
        data_q   <= step_ent[7:4];
      end else if (xfer_end) begin
        // Reached only once init is done or its last step has completed
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        init_done_q <= 1'b1;
      end else begin
        case (state_q)
          S_RESET_WAIT: if (cnt_q == INIT_LAST) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
          end
          S_IDLE: if (g0 || g1) begin
            rs_lat_q     <= sel_rs;
            byte_q       <= sel_byte;
            nib_only_q   <= 1'b0;
            last_grant_q <= g1;
            state_q      <= S_HI_ON;
            cnt_q        <= '0;
            en_q         <= 1'b1;
            rs_q         <= sel_rs;
            data_q       <= sel_byte[7:4];
          end
          S_HI_ON: if (en_done) begin
            state_q <= S_HI_OFF;
            cnt_q   <= '0;
            en_q    <= 1'b0;
          end
          S_HI_OFF: if (en_done) begin
            state_q <= S_LO_ON;
            cnt_q   <= '0;
            en_q    <= 1'b1;
            data_q  <= byte_q[3:0];
          end
          S_LO_ON: if (en_done) begin
            state_q <= S_LO_OFF;
            cnt_q   <= '0;
            en_q    <= 1'b0;
          end
          S_LO_OFF: if (en_done) begin
            state_q <= S_CMD_WAIT;
            cnt_q   <= '0;
          end
          S_CMD_WAIT: ;
          default: begin
            state_q <= S_RESET_WAIT;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign req0_ready = g0;
  assign req1_ready = g1;
  assign rs         = rs_q;
  assign en         = en_q;
  assign data       = data_q;
  assign busy       = (state_q != S_IDLE);
  assign init_done  = init_done_q;
endmodule
